// File: rtl/mfcc_melbank_reader_if.sv
// mfcc_melbank_reader_if
//   Bundles the power-bin input stream, the coefficient ROM read port and the
//   filter-energy output stream of mfcc_melbank_reader.
//   Ports (signals):
//     in_valid/in_ready/in_data/in_last    power bin stream (upstream FFT power stage)
//     rom_addr/rom_data                    coefficient ROM read port
//     out_valid/out_ready/out_data/out_sat filter energy stream (downstream log/DCT stage)
//     frame_err                            frame length disagreement pulse
//   Modports:
//     master  the reader itself
//     slave   the surrounding system (power source, ROM, energy consumer)
interface mfcc_melbank_reader_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int PW_W       = 32,
    parameter int OUT_W      = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [PW_W-1:0]       in_data;
    logic                  in_last;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out_data;
    logic                  out_sat;
    logic                  frame_err;

    modport master (
        input  in_valid, in_data, in_last, rom_data, out_ready,
        output in_ready, rom_addr, out_valid, out_data, out_sat, frame_err
    );

    modport slave (
        output in_valid, in_data, in_last, rom_data, out_ready,
        input  in_ready, rom_addr, out_valid, out_data, out_sat, frame_err
    );
endinterface

// File: rtl/mfcc_melbank_reader.sv
// mfcc_melbank_reader
//   Read-side initiator for one mel filter coefficient ROM. Streams one frame
//   of power-spectrum bins, addresses the ROM with the bin index, accumulates
//   power*weight and emits one filter energy per frame.
//   Ports:
//     clk  clock
//     rst  asynchronous active-high reset
//     bus  mfcc_melbank_reader_if.master (bin stream, ROM port, energy stream)
//   Parameters: ADDR_WIDTH, DATA_WIDTH, NUM_BINS, PW_W, OUT_W,
//     ROM_LAT (0 = combinational ROM, 1 = registered ROM).
//   Configuration macro MELBANK_OUT_SAT_EN: when defined out_data saturates at
//     2**OUT_W-1 and out_sat flags clipping; otherwise out_data is the low
//     OUT_W bits of the accumulator and out_sat is 0.
module mfcc_melbank_reader #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BINS   = 512,
    parameter int PW_W       = 32,
    parameter int OUT_W      = 32,
    parameter int ROM_LAT    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    mfcc_melbank_reader_if.master  bus
);
    localparam int PROD_W = PW_W + DATA_WIDTH;
    localparam int ACC_W  = PROD_W + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(NUM_BINS - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] bin_cnt;
    logic [ACC_W-1:0]      acc;
    logic                  out_valid_q;
    logic [OUT_W-1:0]      out_data_q;
    logic                  out_sat_q;
    logic                  frame_err_q;

    logic                  in_ready;
    logic                  accept;
    logic                  at_last_bin;
    logic                  eof;
    logic                  handshake;
    logic                  mac_en;
    logic [PW_W-1:0]       mac_pw;
    logic [PROD_W-1:0]     product;
    logic [OUT_W-1:0]      energy;
    logic                  clipped;

    // rst gates in_ready so nothing is accepted while reset is held
    assign in_ready    = (state == RUN) && !rst;
    assign accept      = bus.in_valid && in_ready;
    assign at_last_bin = (bin_cnt == LAST_BIN);
    assign eof         = bus.in_last || at_last_bin;
    assign handshake   = out_valid_q && bus.out_ready;

    // With a registered ROM the weight for an accepted bin arrives one cycle
    // later, so the power is held alongside a pending flag until then.
    generate
        if (ROM_LAT == 0) begin : g_lat0
            assign mac_en = accept;
            assign mac_pw = bus.in_data;
        end else begin : g_lat1
            logic            pend;
            logic [PW_W-1:0] pw_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pend <= 1'b0;
                    pw_q <= '0;
                end else begin
                    pend <= accept;
                    if (accept) begin
                        pw_q <= bus.in_data;
                    end
                end
            end

            assign mac_en = pend;
            assign mac_pw = pw_q;
        end
    endgenerate

    assign product = PROD_W'(mac_pw) * PROD_W'(bus.rom_data);

`ifdef MELBANK_OUT_SAT_EN
    localparam logic [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
    assign clipped = (acc > OUT_MAX);
    assign energy  = clipped ? {OUT_W{1'b1}} : acc[OUT_W-1:0];
`else
    assign clipped = 1'b0;
    assign energy  = acc[OUT_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // DRAIN only exists to let the final registered-ROM MAC land in acc
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (accept && eof) state_nxt = (ROM_LAT == 0) ? DONE : DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    if (handshake) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Energy is captured one cycle after acc is final and held until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_cnt     <= '0;
            acc         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= accept && (bus.in_last != at_last_bin);
            if (accept) begin
                bin_cnt <= eof ? '0 : bin_cnt + ADDR_WIDTH'(1);
            end
            if (handshake) begin
                acc <= '0;
            end else if (mac_en) begin
                acc <= acc + ACC_W'(product);
            end
            if (handshake) begin
                out_valid_q <= 1'b0;
            end else if (state == DONE && !out_valid_q) begin
                out_valid_q <= 1'b1;
                out_data_q  <= energy;
                out_sat_q   <= clipped;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.rom_addr  = bin_cnt;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_mfcc_melbank_reader.sv
// tb_mfcc_melbank_reader
//   Drives two readers (ROM_LAT=0 with a combinational ROM, ROM_LAT=1 with a
//   registered ROM) from one shared stimulus, steering it to the instance
//   selected by 'sel'. Expected energies come from summing power*weight over
//   the bins accepted in each frame.
module tb_mfcc_melbank_reader;
    localparam int NB = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [31:0] in_data;
    logic [7:0]  weights [NB];
    logic [7:0]  rom_q1;

    int n_cmp = 0;
    int n_bad = 0;

    mfcc_melbank_reader_if b0 ();
    mfcc_melbank_reader_if b1 ();

    mfcc_melbank_reader #(.ROM_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    mfcc_melbank_reader #(.ROM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    assign b0.in_valid  = in_valid && !sel;
    assign b1.in_valid  = in_valid && sel;
    assign b0.in_last   = in_last && !sel;
    assign b1.in_last   = in_last && sel;
    assign b0.in_data   = in_data;
    assign b1.in_data   = in_data;
    assign b0.out_ready = out_ready && !sel;
    assign b1.out_ready = out_ready && sel;
    assign b0.rom_data  = weights[b0.rom_addr];

    always @(posedge clk) rom_q1 <= weights[b1.rom_addr];
    assign b1.rom_data = rom_q1;

    logic        o_in_ready, o_out_valid, o_out_sat, o_frame_err;
    logic [8:0]  o_rom_addr;
    logic [31:0] o_out_data;
    assign o_in_ready  = sel ? b1.in_ready  : b0.in_ready;
    assign o_out_valid = sel ? b1.out_valid : b0.out_valid;
    assign o_out_sat   = sel ? b1.out_sat   : b0.out_sat;
    assign o_frame_err = sel ? b1.frame_err : b0.frame_err;
    assign o_rom_addr  = sel ? b1.rom_addr  : b0.rom_addr;
    assign o_out_data  = sel ? b1.out_data  : b0.out_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_out(input logic [63:0] a);
`ifdef MELBANK_OUT_SAT_EN
        return (a > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : a[31:0];
`else
        return a[31:0];
`endif
    endfunction

    function automatic logic exp_sat(input logic [63:0] a);
`ifdef MELBANK_OUT_SAT_EN
        return (a > 64'hFFFF_FFFF);
`else
        return (a != a);
`endif
    endfunction

    // Streams one frame, waits for the energy, holds out_ready low for 'hold'
    // cycles, then completes the handshake. last_idx < 0 means no in_last.
    task automatic apply_stimulus(input string tag, input int last_idx, input int gap_pct,
                                  input bit rand_pw, input logic [31:0] pw_fixed,
                                  input int hold, output logic [31:0] got);
        logic [63:0] exp_acc;
        logic [31:0] pw;
        int          k;
        int          cyc;
        int          lat;
        bit          done;
        bit          exp_err;
        bit          addr_ok;
        bit          rdy_ok;
        bit          hold_ok;
        exp_acc = '0;
        k       = 0;
        cyc     = 0;
        done    = 1'b0;
        exp_err = 1'b0;
        addr_ok = 1'b1;
        rdy_ok  = 1'b1;
        while (!done && cyc < 4000) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            pw       = rand_pw ? $urandom : pw_fixed;
            in_data  = pw;
            in_last  = (k == last_idx);
            if (!o_in_ready) rdy_ok = 1'b0;
            if (in_valid && o_in_ready) begin
                if (o_rom_addr !== 9'(k)) addr_ok = 1'b0;
                exp_acc = exp_acc + 64'(pw) * 64'(weights[k]);
                if (k == last_idx || k == NB - 1) begin
                    done    = 1'b1;
                    exp_err = ((k == last_idx) != (k == NB - 1));
                end
                k++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({tag, "_frame_end"}, 64'(done), 64'd1);
        check({tag, "_in_ready_run"}, 64'(rdy_ok), 64'd1);
        check({tag, "_addr_walk"}, 64'(addr_ok), 64'd1);
        check({tag, "_frame_err"}, 64'(o_frame_err), 64'(exp_err));
        lat    = 0;
        rdy_ok = 1'b1;
        while (!o_out_valid && lat < 10) begin
            if (o_in_ready) rdy_ok = 1'b0;
            step();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), sel ? 64'd2 : 64'd1);
        check({tag, "_in_ready_drain"}, 64'(rdy_ok), 64'd1);
        check({tag, "_frame_err_pulse"}, 64'(o_frame_err), 64'd0);
        check({tag, "_out_data"}, 64'(o_out_data), 64'(exp_out(exp_acc)));
        check({tag, "_out_sat"}, 64'(o_out_sat), 64'(exp_sat(exp_acc)));
        got     = o_out_data;
        hold_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            step();
            if (!o_out_valid || o_in_ready || o_out_data !== got) hold_ok = 1'b0;
        end
        if (hold > 0) check({tag, "_hold"}, 64'(hold_ok), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_out_valid_clr"}, 64'(o_out_valid), 64'd0);
        check({tag, "_in_ready_next"}, 64'(o_in_ready), 64'd1);
    endtask

    task automatic check_output(input string tag);
        check({tag, "_in_ready"}, 64'(o_in_ready), 64'd0);
        check({tag, "_out_valid"}, 64'(o_out_valid), 64'd0);
        check({tag, "_out_data"}, 64'(o_out_data), 64'd0);
        check({tag, "_out_sat"}, 64'(o_out_sat), 64'd0);
        check({tag, "_frame_err"}, 64'(o_frame_err), 64'd0);
        check({tag, "_rom_addr"}, 64'(o_rom_addr), 64'd0);
    endtask

    initial begin
        logic [31:0] got;
        int          li;
        rst       = 1'b1;
        sel       = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < NB; i++) weights[i] = 8'd1;
        repeat (3) step();
        check_output("reset0");
        sel = 1'b1;
        check_output("reset1");
        rst = 1'b0;
        #1;
        check("release_in_ready", 64'(o_in_ready), 64'd1);

        // unit weights, unit power, full frame, no gaps
        sel = 1'b0;
        apply_stimulus("t1", NB - 1, 0, 1'b0, 32'd1, 0, got);
        check("t1_value", 64'(got), 64'd512);

        // ramp weights, power 2, registered ROM
        sel = 1'b1;
        for (int i = 0; i < NB; i++) weights[i] = 8'(i);
        apply_stimulus("t2", NB - 1, 0, 1'b0, 32'd2, 0, got);
        check("t2_value", 64'(got), 64'd130560);

        // early in_last on bin 9, both latencies
        for (int i = 0; i < NB; i++) weights[i] = 8'd1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            apply_stimulus("t3", 9, 0, 1'b0, 32'd1, 0, got);
            check("t3_value", 64'(got), 64'd10);
            apply_stimulus("t3_next", NB - 1, 0, 1'b0, 32'd1, 5, got);
            check("t4_value", 64'(got), 64'd512);
        end

        // maximum power and weight
        for (int i = 0; i < NB; i++) weights[i] = 8'd255;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            apply_stimulus("t5", NB - 1, 0, 1'b0, 32'hFFFF_FFFF, 1, got);
`ifdef MELBANK_OUT_SAT_EN
            check("t5_value", 64'(got), 64'hFFFF_FFFF);
`else
            check("t5_value", 64'(got), 64'hFFFE_0200);
`endif
        end

        // reset in the middle of a frame
        for (int i = 0; i < NB; i++) weights[i] = 8'd1;
        sel      = 1'b1;
        in_data  = 32'd1;
        in_valid = 1'b1;
        repeat (100) step();
        in_valid = 1'b0;
        check("t6_addr_before", 64'(o_rom_addr), 64'd100);
        rst = 1'b1;
        #1;
        check_output("t6_rst");
        step();
        rst = 1'b0;
        #1;
        check("t6_in_ready", 64'(o_in_ready), 64'd1);
        apply_stimulus("t6", NB - 1, 0, 1'b0, 32'd1, 0, got);
        check("t6_value", 64'(got), 64'd512);

        // randomized frames: random weights, power, gaps and frame endings
        for (int f = 0; f < 12; f++) begin
            sel = f[0];
            for (int i = 0; i < NB; i++) weights[i] = 8'($urandom);
            case ($urandom_range(2))
                0:       li = -1;
                1:       li = NB - 1;
                default: li = int'($urandom_range(NB - 1));
            endcase
            apply_stimulus("rnd", li, 30, 1'b1, 32'd0, int'($urandom_range(3)), got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
